// File: rtl/udc_bus_master.sv
// Host-side sequencer: programs the up/down counter, pulses start, reports status.
// Define UDC_READBACK_VERIFY_EN to read back and verify the four registers first.
module udc_bus_master #(
    parameter int STROBE_CYCLES = 1,
    parameter int TIMEOUT       = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [7:0] cfg_plr,
    input  logic [7:0] cfg_ulr,
    input  logic [7:0] cfg_llr,
    input  logic [7:0] cfg_ccr,
    inout  wire  [7:0] din,
    output logic       ncs,
    output logic       nwr,
    output logic       nrd,
    output logic       a0,
    output logic       a1,
    output logic       start,
    input  logic       ec,
    input  logic       err,
    output logic       done,
    output logic [1:0] status
);

    localparam int SW = $clog2(STROBE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STB_LAST = SW'(STROBE_CYCLES - 1);
    localparam logic [TW-1:0] RUN_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] SETTLE   = TW'(2);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_SETUP,
        S_WR_STROBE,
        S_WR_HOLD,
`ifdef UDC_READBACK_VERIFY_EN
        S_RD_SETUP,
        S_RD_STROBE,
        S_RD_HOLD,
`endif
        S_START,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state;
    logic [1:0]      idx;
    logic [7:0]      val [4];
    logic [SW-1:0]   stb_cnt;
    logic [TW-1:0]   run_cnt;
    logic            drv;
    logic [7:0]      dout;

    // The bus is only ever driven by us inside write frames.
    assign din = drv ? dout : 8'hzz;

`ifdef UDC_READBACK_VERIFY_EN
    logic mism;
    logic nrd_q;
    assign nrd = nrd_q;
`else
    assign nrd = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            idx       <= 2'd0;
            val       <= '{default: 8'h00};
            stb_cnt   <= '0;
            run_cnt   <= '0;
            drv       <= 1'b0;
            dout      <= 8'h00;
            ncs       <= 1'b1;
            nwr       <= 1'b1;
            a0        <= 1'b0;
            a1        <= 1'b0;
            start     <= 1'b0;
            done      <= 1'b0;
            status    <= 2'b00;
            cfg_ready <= 1'b1;
`ifdef UDC_READBACK_VERIFY_EN
            mism      <= 1'b0;
            nrd_q     <= 1'b1;
`endif
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (cfg_valid) begin
                        val[0]    <= cfg_plr;
                        val[1]    <= cfg_ulr;
                        val[2]    <= cfg_llr;
                        val[3]    <= cfg_ccr;
                        idx       <= 2'd0;
                        {a1, a0}  <= 2'b00;
                        dout      <= cfg_plr;
                        drv       <= 1'b1;
                        ncs       <= 1'b0;
                        stb_cnt   <= '0;
                        status    <= 2'b00;
                        cfg_ready <= 1'b0;
`ifdef UDC_READBACK_VERIFY_EN
                        mism      <= 1'b0;
`endif
                        state     <= S_WR_SETUP;
                    end
                end
                S_WR_SETUP: begin
                    nwr   <= 1'b0;
                    state <= S_WR_STROBE;
                end
                S_WR_STROBE: begin
                    if (stb_cnt == STB_LAST) begin
                        nwr     <= 1'b1;
                        stb_cnt <= '0;
                        state   <= S_WR_HOLD;
                    end else begin
                        stb_cnt <= stb_cnt + SW'(1);
                    end
                end
                S_WR_HOLD: begin
                    if (idx == 2'd3) begin
                        drv   <= 1'b0;
`ifdef UDC_READBACK_VERIFY_EN
                        idx      <= 2'd0;
                        {a1, a0} <= 2'b00;
                        state    <= S_RD_SETUP;
`else
                        ncs   <= 1'b1;
                        start <= 1'b1;
                        state <= S_START;
`endif
                    end else begin
                        idx      <= idx + 2'd1;
                        {a1, a0} <= idx + 2'd1;
                        dout     <= val[idx + 2'd1];
                        state    <= S_WR_SETUP;
                    end
                end
`ifdef UDC_READBACK_VERIFY_EN
                S_RD_SETUP: begin
                    nrd_q <= 1'b0;
                    state <= S_RD_STROBE;
                end
                S_RD_STROBE: begin
                    if (stb_cnt == STB_LAST) begin
                        if (din != val[idx]) mism <= 1'b1;
                        nrd_q   <= 1'b1;
                        stb_cnt <= '0;
                        state   <= S_RD_HOLD;
                    end else begin
                        stb_cnt <= stb_cnt + SW'(1);
                    end
                end
                S_RD_HOLD: begin
                    if (idx == 2'd3) begin
                        ncs <= 1'b1;
                        if (mism) begin
                            done   <= 1'b1;
                            status <= 2'b11;
                            state  <= S_DONE;
                        end else begin
                            start <= 1'b1;
                            state <= S_START;
                        end
                    end else begin
                        idx      <= idx + 2'd1;
                        {a1, a0} <= idx + 2'd1;
                        state    <= S_RD_SETUP;
                    end
                end
`endif
                S_START: begin
                    start   <= 1'b0;
                    run_cnt <= '0;
                    state   <= S_RUN;
                end
                S_RUN: begin
                    run_cnt <= run_cnt + TW'(1);
                    // ec/err are stale for two cycles after start.
                    if (run_cnt >= SETTLE && err) begin
                        done   <= 1'b1;
                        status <= 2'b01;
                        state  <= S_DONE;
                    end else if (run_cnt >= SETTLE && ec) begin
                        done   <= 1'b1;
                        status <= 2'b00;
                        state  <= S_DONE;
                    end else if (run_cnt == RUN_LAST) begin
                        done   <= 1'b1;
                        status <= 2'b10;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    done      <= 1'b0;
                    cfg_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_udc_bus_master.sv
// Self-checking bench for udc_bus_master with a register-port stub model.
// Build with +define+UDC_READBACK_VERIFY_EN to exercise the readback variant.
module tb_udc_bus_master;

    localparam int S      = 1;
    localparam int TMO    = 64;
    localparam int FR     = 2 + S;
    localparam int WR_END = 4 * FR;

    logic       clk;
    logic       reset;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_plr, cfg_ulr, cfg_llr, cfg_ccr;
    wire  [7:0] din;
    logic       ncs, nwr, nrd, a0, a1;
    logic       start;
    logic       ec, err;
    logic       done;
    logic [1:0] status;

    int errors = 0;
    int checks = 0;

    logic [7:0] stub_reg [4];
    logic       corrupt_ulr;
    logic [7:0] stub_val;

    udc_bus_master #(.STROBE_CYCLES(S), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_plr(cfg_plr), .cfg_ulr(cfg_ulr),
        .cfg_llr(cfg_llr), .cfg_ccr(cfg_ccr),
        .din(din), .ncs(ncs), .nwr(nwr), .nrd(nrd),
        .a0(a0), .a1(a1), .start(start),
        .ec(ec), .err(err), .done(done), .status(status)
    );

    // Counter-side stub: answers reads, and parks 8'hA5 on the idle bus
    // so a released din is visible as that pattern.
    always_comb begin
        stub_val = 8'hA5;
        if (!nrd)
            stub_val = (corrupt_ulr && {a1, a0} == 2'd1) ? 8'h07
                                                          : stub_reg[{a1, a0}];
    end
    assign din = (ncs || !nrd) ? stub_val : 8'hzz;

    always @(posedge clk)
        if (!ncs && !nwr) stub_reg[{a1, a0}] <= din;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk(tag, {ncs, nwr, nrd, a1, a0, start, done, status, cfg_ready, din},
            {3'b111, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 8'hA5});
    endtask

    task automatic do_accept(input logic [7:0] p, u, l, c);
        chk("ready_before_accept", cfg_ready, 1'b1);
        cfg_plr   = p;
        cfg_ulr   = u;
        cfg_llr   = l;
        cfg_ccr   = c;
        cfg_valid = 1'b1;
        @(posedge clk);
        #1 cfg_valid = 1'b0;
    endtask

    // Reference: frame layout, start cycle and done cycle/status are derived
    // from cycle arithmetic relative to the accept edge (cycle 0).
    // k = RUN cycle (1-based) from which the selected flag is held high.
    task automatic txn(input logic [7:0] p, u, l, c_, input int k,
                       input bit f_ec, input bit f_err, input bit bad);
        logic [7:0] v [4];
        int es, ed, s, f, ph;
        logic [1:0] est;
        v = '{p, u, l, c_};
`ifdef UDC_READBACK_VERIFY_EN
        es = 2 * WR_END + 1;
`else
        es = WR_END + 1;
`endif
        if (bad) begin
            ed  = 2 * WR_END + 1;
            est = 2'b11;
        end else begin
            s = (k < 3) ? 3 : k;
            if ((f_ec || f_err) && s <= TMO) begin
                ed  = es + s + 1;
                est = f_err ? 2'b01 : 2'b00;
            end else begin
                ed  = es + TMO + 1;
                est = 2'b10;
            end
        end
        corrupt_ulr = bad;
        do_accept(p, u, l, c_);
        for (int c = 1; c <= ed + 1; c++) begin
            @(negedge clk);
            f  = (c - 1) / FR;
            ph = (c - 1) % FR;
            if (c <= WR_END)
                chk("wr_frame", {ncs, nwr, nrd, a1, a0, din},
                    {1'b0, ph != 1, 1'b1, f[1:0], v[f]});
`ifdef UDC_READBACK_VERIFY_EN
            else if (c <= 2 * WR_END) begin
                f = f - 4;
                chk("rd_frame", {ncs, nwr, nrd, a1, a0},
                    {1'b0, 1'b1, ph != 1, f[1:0]});
            end
`endif
            chk("start", start, c == es && !bad);
            chk("done_ready", {done, cfg_ready}, {c == ed, c == ed + 1});
            if (c == ed) chk("status", status, est);
            if (c == es && !bad)
                chk("start_bus", {ncs, nwr, nrd, din}, {3'b111, 8'hA5});
            ec  = f_ec  && !bad && c >= es + k && c < ed;
            err = f_err && !bad && c >= es + k && c < ed;
            // Requests while busy must be ignored.
            cfg_valid = (c < ed) ? 1'($urandom_range(0, 1)) : 1'b0;
            cfg_plr   = 8'($urandom);
            cfg_ulr   = 8'($urandom);
        end
        ec          = 1'b0;
        err         = 1'b0;
        cfg_valid   = 1'b0;
        corrupt_ulr = 1'b0;
    endtask

    initial begin
        int kind;
        reset       = 1'b1;
        cfg_valid   = 1'b0;
        cfg_plr     = 8'h00;
        cfg_ulr     = 8'h00;
        cfg_llr     = 8'h00;
        cfg_ccr     = 8'h00;
        ec          = 1'b0;
        err         = 1'b0;
        corrupt_ulr = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_state("reset_state");
        reset = 1'b0;
        @(negedge clk);
        chk_reset_state("idle_after_reset");

        txn(8'd5, 8'd8, 8'd2, 8'd1, 5, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        txn(8'd10, 8'd8, 8'd2, 8'd3, 1, 1'b0, 1'b1, 1'b0);
        txn(8'd3, 8'd9, 8'd1, 8'd0, 0, 1'b0, 1'b0, 1'b0);
        txn(8'hFF, 8'h00, 8'h80, 8'h7F, 2, 1'b1, 1'b1, 1'b0);
        txn(8'd1, 8'd2, 8'd3, 8'd4, TMO, 1'b1, 1'b0, 1'b0);
        txn(8'd1, 8'd2, 8'd3, 8'd4, TMO + 1, 1'b0, 1'b1, 1'b0);
`ifdef UDC_READBACK_VERIFY_EN
        txn(8'd5, 8'd8, 8'd2, 8'd1, 5, 1'b1, 1'b0, 1'b1);
`endif

        // Reset during the LLR write strobe (cycle 8).
        do_accept(8'd5, 8'd8, 8'd2, 8'd1);
        repeat (8) @(negedge clk);
        chk("llr_strobe", {ncs, nwr, a1, a0, din}, {2'b00, 2'b10, 8'd2});
        reset = 1'b1;
        @(negedge clk);
        chk_reset_state("reset_mid_write");
        reset = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            chk("quiet_after_reset", {start, done, ncs}, 3'b001);
        end
        txn(8'd6, 8'd9, 8'd1, 8'd2, 4, 1'b1, 1'b0, 1'b0);

        for (int r = 0; r < 8; r++) begin
            kind = $urandom_range(0, 2);
            txn(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                $urandom_range(1, TMO + 6), kind != 1, kind != 0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
